// File: rtl/ide_pio_seq.sv
// rtl/ide_pio_seq.sv - IDE PIO cycle sequencer for the $DA0000 window; IORDY handling gated by IDE_IORDY_EN
module ide_pio_seq (
  input  logic       CLKCPU,
  input  logic       RESET,
  input  logic       AS20,
  input  logic       RW20,
  input  logic       IDE_SEL,
  input  logic       A12,
  input  logic       IORDY,
  input  logic       CFG_WR,
  input  logic [7:0] CFG_D,
  output logic       IOR,
  output logic       IOW,
  output logic [1:0] IDECS,
  output logic [1:0] DSACK,
  output logic       TIMEOUT
);

  typedef enum logic [2:0] {IDLE, SETUP, ACTIVE, ACK, RECOVER} state_t;

  state_t     state, state_nx;
  logic [2:0] cnt, cnt_nx;
  logic [7:0] timing;
  logic       dir_rd, dir_rd_nx;
  logic       ior_nx, iow_nx, timeout_nx;
  logic [1:0] idecs_nx, dsack_nx;
  logic       req, ready, expire;
  logic [2:0] setup_val, active_val, recov_val;

  // Counters always load from the register as it stands before the current edge,
  // so a CFG_WR only affects phases that start afterwards.
  assign setup_val  = {1'b0, timing[1:0]};
  assign active_val = timing[4:2];
  assign recov_val  = timing[7:5];
  assign req        = !AS20 && !IDE_SEL;

`ifdef IDE_IORDY_EN
  logic [7:0] wdog;
  assign ready  = IORDY;
  assign expire = !IORDY && (wdog == 8'hFF);

  // Watchdog: zero outside ACTIVE, counts clocks stalled at cnt=0 waiting for IORDY
  always_ff @(posedge CLKCPU or negedge RESET) begin
    if (!RESET)
      wdog <= 8'h00;
    else if (state != ACTIVE)
      wdog <= 8'h00;
    else if (!AS20 && cnt == 3'd0 && !IORDY && !expire)
      wdog <= wdog + 8'd1;
  end
`else
  logic unused_iordy;
  assign unused_iordy = IORDY;
  assign ready        = 1'b1;
  assign expire       = 1'b0;
`endif

  // State, counter, timing register and registered outputs; reset drops every strobe at once
  always_ff @(posedge CLKCPU or negedge RESET) begin
    if (!RESET) begin
      state   <= IDLE;
      cnt     <= 3'd0;
      dir_rd  <= 1'b0;
      timing  <= 8'h4D;
      IOR     <= 1'b1;
      IOW     <= 1'b1;
      IDECS   <= 2'b11;
      DSACK   <= 2'b11;
      TIMEOUT <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      dir_rd  <= dir_rd_nx;
      IOR     <= ior_nx;
      IOW     <= iow_nx;
      IDECS   <= idecs_nx;
      DSACK   <= dsack_nx;
      TIMEOUT <= timeout_nx;
      if (CFG_WR)
        timing <= CFG_D;
    end
  end

  // Next-state and phase counter; AS20 high in SETUP/ACTIVE aborts into RECOVER
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    dir_rd_nx = dir_rd;
    case (state)
      IDLE: if (req) begin
        state_nx = SETUP;
        cnt_nx   = setup_val;
      end
      SETUP: if (AS20) begin
        state_nx = RECOVER;
        cnt_nx   = recov_val;
      end else if (cnt == 3'd0) begin
        state_nx  = ACTIVE;
        cnt_nx    = active_val;
        dir_rd_nx = RW20;
      end else begin
        cnt_nx = cnt - 3'd1;
      end
      ACTIVE: if (AS20) begin
        state_nx = RECOVER;
        cnt_nx   = recov_val;
      end else if (cnt != 3'd0) begin
        cnt_nx = cnt - 3'd1;
      end else if (ready || expire) begin
        state_nx = ACK;
      end
      ACK: if (AS20) begin
        state_nx = RECOVER;
        cnt_nx   = recov_val;
      end
      RECOVER: if (cnt == 3'd0) begin
        state_nx = IDLE;
      end else begin
        cnt_nx = cnt - 3'd1;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Next output values; the strobe in ACTIVE follows the direction latched on entry
  always_comb begin
    ior_nx     = IOR;
    iow_nx     = IOW;
    idecs_nx   = IDECS;
    dsack_nx   = DSACK;
    timeout_nx = 1'b0;
    case (state)
      IDLE: if (req) begin
        idecs_nx = A12 ? 2'b01 : 2'b10;
      end
      SETUP: if (AS20) begin
        ior_nx   = 1'b1;
        iow_nx   = 1'b1;
        idecs_nx = 2'b11;
        dsack_nx = 2'b11;
      end else if (cnt == 3'd0) begin
        ior_nx = !RW20;
        iow_nx = RW20;
      end
      ACTIVE: if (AS20) begin
        ior_nx   = 1'b1;
        iow_nx   = 1'b1;
        idecs_nx = 2'b11;
        dsack_nx = 2'b11;
      end else if (cnt == 3'd0 && (ready || expire)) begin
        ior_nx     = 1'b1;
        iow_nx     = 1'b1;
        dsack_nx   = 2'b01;
        timeout_nx = expire;
      end else begin
        ior_nx = !dir_rd;
        iow_nx = dir_rd;
      end
      ACK: if (AS20) begin
        dsack_nx = 2'b11;
        idecs_nx = 2'b11;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ide_pio_seq.sv
// tb/tb_ide_pio_seq.sv - self-checking bench for ide_pio_seq
module tb_ide_pio_seq;

  logic       CLKCPU, RESET, AS20, RW20, IDE_SEL, A12, IORDY, CFG_WR;
  logic [7:0] CFG_D;
  logic       IOR, IOW, TIMEOUT;
  logic [1:0] IDECS, DSACK;

  ide_pio_seq dut (
    .CLKCPU(CLKCPU), .RESET(RESET), .AS20(AS20), .RW20(RW20), .IDE_SEL(IDE_SEL),
    .A12(A12), .IORDY(IORDY), .CFG_WR(CFG_WR), .CFG_D(CFG_D), .IOR(IOR), .IOW(IOW),
    .IDECS(IDECS), .DSACK(DSACK), .TIMEOUT(TIMEOUT)
  );

  initial CLKCPU = 1'b0;
  always #5 CLKCPU = ~CLKCPU;

`ifdef IDE_IORDY_EN
  localparam int WD_ACT = 259;
  localparam int WD_TO  = 1;
`else
  localparam int WD_ACT = 4;
  localparam int WD_TO  = 0;
`endif

  typedef struct {
    int         id;
    logic [1:0] cs;
    int         setup;
    int         active;
    logic [1:0] strb;
    logic       ack;
    int         to;
  } exp_t;

  typedef struct {
    logic       wr_cfg;
    logic [7:0] cfg;
    logic       a12;
    logic       rw;
    logic       iordy;
    logic       flip;
    int         abort_act;
    exp_t       e;
  } vec_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, want);
    end
  endtask

  function automatic exp_t mk_exp(input int id, input logic [1:0] cs, input int s, input int a,
                                  input logic [1:0] strb, input logic ack, input int to);
    exp_t e;
    e.id = id; e.cs = cs; e.setup = s; e.active = a; e.strb = strb; e.ack = ack; e.to = to;
    return e;
  endfunction

  function automatic vec_t mk_vec(input logic wr_cfg, input logic [7:0] cfg, input logic a12,
                                  input logic rw, input logic iordy, input logic flip,
                                  input int abort_act, input exp_t e);
    vec_t v;
    v.wr_cfg = wr_cfg; v.cfg = cfg; v.a12 = a12; v.rw = rw; v.iordy = iordy;
    v.flip = flip; v.abort_act = abort_act; v.e = e;
    return v;
  endfunction

  // Bus monitor: one transaction = the span with a chip select low
  bit         in_txn = 0;
  int         m_setup, m_active, m_to;
  logic [1:0] m_cs, m_strb;
  logic       m_ack, m_both;
  exp_t       e_pop;

  always @(negedge CLKCPU) begin
    if (IDECS != 2'b11) begin
      if (!in_txn) begin
        in_txn = 1; m_cs = IDECS; m_setup = 0; m_active = 0; m_to = 0;
        m_strb = 2'b00; m_ack = 1'b0; m_both = 1'b0;
      end
      if (IOR && IOW && DSACK == 2'b11 && m_active == 0) m_setup++;
      if (!IOR || !IOW) m_active++;
      if (!IOR) m_strb[1] = 1'b1;
      if (!IOW) m_strb[0] = 1'b1;
      if (!IOR && !IOW) m_both = 1'b1;
      if (DSACK == 2'b01) m_ack = 1'b1;
      if (TIMEOUT) m_to++;
    end else if (in_txn) begin
      in_txn = 0;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_unexpected: got a bus cycle, expected none");
      end else begin
        e_pop = exp_q.pop_front();
        chk($sformatf("t%0d_cs", e_pop.id), int'(m_cs), int'(e_pop.cs));
        chk($sformatf("t%0d_setup", e_pop.id), m_setup, e_pop.setup);
        chk($sformatf("t%0d_active", e_pop.id), m_active, e_pop.active);
        chk($sformatf("t%0d_strobe", e_pop.id), int'(m_strb), int'(e_pop.strb));
        chk($sformatf("t%0d_dsack", e_pop.id), int'(m_ack), int'(e_pop.ack));
        chk($sformatf("t%0d_timeout", e_pop.id), m_to, e_pop.to);
        chk($sformatf("t%0d_both_low", e_pop.id), int'(m_both), 0);
      end
    end
  end

  task automatic drive_until(input vec_t v);
    int n, nact;
    bit done;
    if (v.wr_cfg) begin
      @(posedge CLKCPU); #1;
      CFG_WR = 1'b1; CFG_D = v.cfg;
      @(posedge CLKCPU); #1;
      CFG_WR = 1'b0;
    end else begin
      @(posedge CLKCPU); #1;
    end
    exp_q.push_back(v.e);
    A12 = v.a12; RW20 = v.rw; IORDY = v.iordy; IDE_SEL = 1'b0; AS20 = 1'b0;
    n = 0; nact = 0; done = 0;
    while (!done && n < 2000) begin
      @(negedge CLKCPU);
      n++;
      if (!IOR || !IOW) begin
        nact++;
        if (v.flip && nact == 1) RW20 = ~v.rw;
      end
      if (v.abort_act == 0 && IDECS != 2'b11) done = 1;
      if (v.abort_act > 0 && nact == v.abort_act) done = 1;
      if (v.abort_act < 0 && DSACK == 2'b01) done = 1;
    end
    chk($sformatf("t%0d_reached", v.e.id), int'(done), 1);
    AS20 = 1'b1; IDE_SEL = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    drive_until(v);
    RW20 = 1'b1; IORDY = 1'b1;
    repeat (12) @(negedge CLKCPU);
  endtask

  // Re-request right after release and count clocks the request is held off
  task automatic gap_seq(input vec_t v, input exp_t e2, input int want_hold, input string nm);
    int hold, n;
    bit seen;
    drive_until(v);
    @(negedge CLKCPU);
    exp_q.push_back(e2);
    RW20 = v.rw; IORDY = 1'b1; IDE_SEL = 1'b0; AS20 = 1'b0;
    hold = 0; seen = 0;
    while (!seen && hold < 50) begin
      @(negedge CLKCPU);
      if (IDECS != 2'b11) seen = 1;
      else hold++;
    end
    chk(nm, hold, want_hold);
    n = 0;
    while (DSACK != 2'b01 && n < 100) begin
      @(negedge CLKCPU);
      n++;
    end
    chk({nm, "_ack"}, int'(DSACK == 2'b01), 1);
    AS20 = 1'b1; IDE_SEL = 1'b1;
    repeat (12) @(negedge CLKCPU);
  endtask

  vec_t tbl[9];

  initial begin
    AS20 = 1'b1; IDE_SEL = 1'b1; RW20 = 1'b1; A12 = 1'b0; IORDY = 1'b1;
    CFG_WR = 1'b0; CFG_D = 8'h00; RESET = 1'b0;

    //                 wr cfg    a12 rw rdy flp abort       id  cs    set act strb  ack to
    tbl[0] = mk_vec(1, 8'h4D, 0, 1, 1, 0, -1, mk_exp(1, 2'b10, 2, 4, 2'b10, 1, 0));
    tbl[1] = mk_vec(1, 8'h00, 1, 0, 1, 0, -1, mk_exp(2, 2'b01, 1, 1, 2'b01, 1, 0));
    tbl[2] = mk_vec(1, 8'h4D, 0, 1, 1, 0,  2, mk_exp(3, 2'b10, 2, 2, 2'b10, 0, 0));
    tbl[3] = mk_vec(1, 8'hFF, 1, 1, 1, 0, -1, mk_exp(4, 2'b01, 4, 8, 2'b10, 1, 0));
    tbl[4] = mk_vec(1, 8'h1E, 0, 0, 1, 0, -1, mk_exp(5, 2'b10, 3, 8, 2'b01, 1, 0));
    tbl[5] = mk_vec(1, 8'h8B, 1, 1, 1, 0,  0, mk_exp(6, 2'b01, 1, 0, 2'b00, 0, 0));
    tbl[6] = mk_vec(1, 8'h24, 1, 0, 1, 0,  1, mk_exp(7, 2'b01, 1, 1, 2'b01, 0, 0));
    tbl[7] = mk_vec(1, 8'h4D, 0, 1, 1, 1, -1, mk_exp(8, 2'b10, 2, 4, 2'b10, 1, 0));
    tbl[8] = mk_vec(1, 8'h4D, 0, 1, 0, 0, -1, mk_exp(9, 2'b10, 2, WD_ACT, 2'b10, 1, WD_TO));

    repeat (3) @(negedge CLKCPU);
    chk("rst_ior", int'(IOR), 1);
    chk("rst_iow", int'(IOW), 1);
    chk("rst_idecs", int'(IDECS), 3);
    chk("rst_dsack", int'(DSACK), 3);
    chk("rst_timeout", int'(TIMEOUT), 0);
    @(posedge CLKCPU); #2;
    RESET = 1'b1;
    repeat (3) @(negedge CLKCPU);
    chk("idle_idecs", int'(IDECS), 3);

    for (int i = 0; i < 9; i++) run_vec(tbl[i]);

    gap_seq(mk_vec(1, 8'h4D, 0, 1, 1, 0, -1, mk_exp(20, 2'b10, 2, 4, 2'b10, 1, 0)),
            mk_exp(21, 2'b10, 2, 4, 2'b10, 1, 0), 3, "gap_rec2");
    gap_seq(mk_vec(1, 8'h00, 1, 0, 1, 0, -1, mk_exp(22, 2'b01, 1, 1, 2'b01, 1, 0)),
            mk_exp(23, 2'b01, 1, 1, 2'b01, 1, 0), 1, "gap_rec0");
    gap_seq(mk_vec(1, 8'h4D, 0, 1, 1, 0, 2, mk_exp(24, 2'b10, 2, 2, 2'b10, 0, 0)),
            mk_exp(25, 2'b10, 2, 4, 2'b10, 1, 0), 3, "gap_abort");

    // Asynchronous reset in the middle of a write strobe
    drive_until(mk_vec(1, 8'hFF, 1, 0, 1, 0, 2, mk_exp(30, 2'b01, 4, 2, 2'b01, 0, 0)));
    #1 RESET = 1'b0;
    #1;
    chk("arst_iow", int'(IOW), 1);
    chk("arst_ior", int'(IOR), 1);
    chk("arst_idecs", int'(IDECS), 3);
    chk("arst_dsack", int'(DSACK), 3);
    @(posedge CLKCPU); #2;
    RESET = 1'b1;
    repeat (3) @(negedge CLKCPU);
    run_vec(mk_vec(0, 8'h00, 0, 1, 1, 0, -1, mk_exp(31, 2'b10, 2, 4, 2'b10, 1, 0)));

    chk("sb_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "bench time limit");
  end

endmodule
